pipe_hazard_ctrl: RTL and testbench

//  Central hazard controller for the 5-stage RV32I pipeline (IF/ID/EX/ME/WB).

---
 rtl/pipe_pkg.sv | 19 +
 rtl/hazard_match.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forward-select codes,
// controller FSM states and a saturating counter helper.
package pipe_pkg;

   localparam logic [1:0]  FWD_RF  = 2'b00;
   localparam logic [1:0]  FWD_ME  = 2'b01;
   localparam logic [1:0]  FWD_WB  = 2'b10;
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } hz_state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == CNT_MAX) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/hazard_match.sv
// One ID source operand against one downstream stage's destination.
// Purely combinational, zero latency, no flow control.
module hazard_match #(
   parameter int REG_AW = 5
) (
   input  logic              id_valid,
   input  logic              rs_used,
   input  logic [REG_AW-1:0] rs,
   input  logic              s_valid,
   input  logic              s_wreg,
   input  logic [REG_AW-1:0] s_rd,
   output logic              match
);

   // x0 is hardwired zero, so it never carries a dependency.
   assign match = id_valid & rs_used & s_valid & s_wreg & (s_rd == rs) & (rs != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stage enables/flushes are combinational
// in the current cycle; forward selects, abort/timeout and counters register on the edge.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int NSRC   = 2,
   parameter int FWD_EN = 1,
   parameter int MC_MAX = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [NSRC*REG_AW-1:0] id_rs,
   input  logic [NSRC-1:0]        id_rs_used,
   input  logic                   ex_valid,
   input  logic                   ex_wreg,
   input  logic                   ex_is_load,
   input  logic                   ex_is_mc,
   input  logic [REG_AW-1:0]      ex_rd,
   input  logic                   me_valid,
   input  logic                   me_wreg,
   input  logic [REG_AW-1:0]      me_rd,
   input  logic                   redirect,
   input  logic                   mc_done,
   output logic                   pc_en,
   output logic                   if_id_en,
   output logic                   id_ex_en,
   output logic                   ex_me_en,
   output logic                   if_id_flush,
   output logic                   id_ex_flush,
   output logic                   ex_me_flush,
   output logic [2*NSRC-1:0]      fwd_sel,
   output logic                   mc_abort,
   output logic                   mc_timeout,
   output logic [31:0]            stall_cnt,
   output logic [31:0]            flush_cnt
);

   localparam int            CW      = $clog2(MC_MAX);
   localparam logic [CW-1:0] MC_LAST = CW'(MC_MAX - 1);

   logic [NSRC-1:0] m_ex, m_me;

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      hazard_match #(.REG_AW(REG_AW)) u_ex (
         .id_valid (id_valid),
         .rs_used  (id_rs_used[i]),
         .rs       (id_rs[i*REG_AW +: REG_AW]),
         .s_valid  (ex_valid),
         .s_wreg   (ex_wreg),
         .s_rd     (ex_rd),
         .match    (m_ex[i])
      );
      hazard_match #(.REG_AW(REG_AW)) u_me (
         .id_valid (id_valid),
         .rs_used  (id_rs_used[i]),
         .rs       (id_rs[i*REG_AW +: REG_AW]),
         .s_valid  (me_valid),
         .s_wreg   (me_wreg),
         .s_rd     (me_rd),
         .match    (m_me[i])
      );
   end

   hz_state_e         state_q, state_d;
   logic [CW-1:0]     mc_cnt_q, mc_cnt_d;
   logic [2*NSRC-1:0] fwd_q, fwd_d;
   logic              abort_q, abort_d;
   logic              tmo_q, tmo_d;
   logic [31:0]       stall_cnt_q, stall_cnt_d;
   logic [31:0]       flush_cnt_q, flush_cnt_d;
   logic              waiting, mc_expire, data_stall;

   always_comb begin
      waiting   = (state_q == MC_WAIT) & ~redirect & ~mc_done;
      mc_expire = waiting & (mc_cnt_q == MC_LAST);
      if (FWD_EN != 0) data_stall = ex_is_load & (|m_ex);
      else             data_stall = |(m_ex | m_me);

      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_me_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ex_me_flush = 1'b0;
      if (redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         ex_me_flush = 1'b1;
      end else if (waiting) begin
         // Multi-cycle op parks in EX; ME sees bubbles; expiry also kills the op in EX.
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_en    = 1'b0;
         ex_me_flush = 1'b1;
         id_ex_flush = mc_expire;
      end else if (data_stall) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      mc_cnt_d = mc_cnt_q;
      abort_d  = 1'b0;
      tmo_d    = tmo_q;
      if (redirect) begin
         abort_d = (state_q == MC_WAIT);
         state_d = RUN;
      end else if (state_q == MC_WAIT) begin
         if (mc_done) begin
            state_d = RUN;
         end else if (mc_expire) begin
            state_d = RUN;
            abort_d = 1'b1;
            tmo_d   = 1'b1;
         end else begin
            mc_cnt_d = mc_cnt_q + CW'(1);
         end
      end else if (ex_valid & ex_is_mc) begin
         state_d  = MC_WAIT;
         mc_cnt_d = '0;
      end

      stall_cnt_d = (~pc_en & ~redirect) ? sat_inc(stall_cnt_q) : stall_cnt_q;
      flush_cnt_d = redirect ? sat_inc(flush_cnt_q) : flush_cnt_q;

      fwd_d = fwd_q;
      if (id_ex_flush) begin
         fwd_d = '0;
      end else if (id_ex_en) begin
         for (int i = 0; i < NSRC; i++) begin
            if (FWD_EN == 0)  fwd_d[2*i +: 2] = FWD_RF;
            else if (m_ex[i]) fwd_d[2*i +: 2] = FWD_ME;
            else if (m_me[i]) fwd_d[2*i +: 2] = FWD_WB;
            else              fwd_d[2*i +: 2] = FWD_RF;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         mc_cnt_q    <= '0;
         fwd_q       <= '0;
         abort_q     <= 1'b0;
         tmo_q       <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mc_cnt_q    <= mc_cnt_d;
         fwd_q       <= fwd_d;
         abort_q     <= abort_d;
         tmo_q       <= tmo_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fwd_sel    = fwd_q;
   assign mc_abort   = abort_q;
   assign mc_timeout = tmo_q;
   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios with literal expectations,
// then random traffic checked every cycle against a cycle-level pipeline model.
module tb_pipe_hazard_ctrl;

   localparam int AW  = 5;
   localparam int NS  = 2;
   localparam int MCM = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [NS*AW-1:0] id_rs;
   logic [NS-1:0] id_rs_used;
   logic          ex_valid, ex_wreg, ex_is_load, ex_is_mc;
   logic [AW-1:0] ex_rd;
   logic          me_valid, me_wreg;
   logic [AW-1:0] me_rd;
   logic          redirect, mc_done;
   logic          pc_en, if_id_en, id_ex_en, ex_me_en;
   logic          if_id_flush, id_ex_flush, ex_me_flush;
   logic [2*NS-1:0] fwd_sel;
   logic          mc_abort, mc_timeout;
   logic [31:0]   stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_AW(AW), .NSRC(NS), .FWD_EN(1), .MC_MAX(MCM)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_is_mc(ex_is_mc),
      .ex_rd(ex_rd), .me_valid(me_valid), .me_wreg(me_wreg), .me_rd(me_rd),
      .redirect(redirect), .mc_done(mc_done), .pc_en(pc_en), .if_id_en(if_id_en),
      .id_ex_en(id_ex_en), .ex_me_en(ex_me_en), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .ex_me_flush(ex_me_flush), .fwd_sel(fwd_sel),
      .mc_abort(mc_abort), .mc_timeout(mc_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: wait-phase bookkeeping, forward selects per source, counters.
   bit         m_wait;
   int         m_wcnt;
   logic [1:0] m_fwd [NS];
   longint     m_stall, m_flush;
   bit         m_abort, m_tmo;

   function automatic bit src_hits(int i, logic sv, logic sw, logic [AW-1:0] rd);
      logic [AW-1:0] r;
      r = id_rs[i*AW +: AW];
      return id_valid && id_rs_used[i] && sv && sw && (r == rd) && (r != 0);
   endfunction

   always @(negedge clk) begin
      bit hx [NS];
      bit hm [NS];
      bit any_ex, held, expire;
      logic [3:0] e;
      logic [2:0] f;
      logic [2*NS-1:0] fw;
      if (!rst) begin
         m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_abort = 0; m_tmo = 0;
         for (int i = 0; i < NS; i++) m_fwd[i] = 2'b00;
      end
      any_ex = 0;
      for (int i = 0; i < NS; i++) begin
         hx[i] = src_hits(i, ex_valid, ex_wreg, ex_rd);
         hm[i] = src_hits(i, me_valid, me_wreg, me_rd);
         any_ex = any_ex | hx[i];
      end
      held   = m_wait && !redirect && !mc_done;
      expire = held && (m_wcnt + 1 == MCM);
      if (redirect)                   begin e = 4'b1111; f = 3'b111; end
      else if (held)                  begin e = 4'b0001; f = {1'b0, expire, 1'b1}; end
      else if (any_ex && ex_is_load)  begin e = 4'b0011; f = 3'b010; end
      else                            begin e = 4'b1111; f = 3'b000; end
      for (int i = 0; i < NS; i++) fw[2*i +: 2] = m_fwd[i];

      chk("enables", {pc_en, if_id_en, id_ex_en, ex_me_en}, e);
      chk("flushes", {if_id_flush, id_ex_flush, ex_me_flush}, f);
      chk("fwd_sel", fwd_sel, fw);
      chk("mc_abort", mc_abort, m_abort);
      chk("mc_timeout", mc_timeout, m_tmo);
      chk("stall_cnt", stall_cnt, m_stall[31:0]);
      chk("flush_cnt", flush_cnt, m_flush[31:0]);

      if (rst) begin
         if (!e[3] && !redirect && m_stall < 64'hFFFF_FFFF) m_stall++;
         if (redirect && m_flush < 64'hFFFF_FFFF) m_flush++;
         m_abort = (m_wait && redirect) || expire;
         if (expire) m_tmo = 1;
         for (int i = 0; i < NS; i++) begin
            if (f[1])      m_fwd[i] = 2'b00;
            else if (e[1]) m_fwd[i] = hx[i] ? 2'b01 : (hm[i] ? 2'b10 : 2'b00);
         end
         if (redirect) m_wait = 0;
         else if (m_wait) begin
            if (mc_done || expire) m_wait = 0;
            else m_wcnt++;
         end else if (ex_valid && ex_is_mc) begin
            m_wait = 1;
            m_wcnt = 0;
         end
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask
   task automatic mid();  @(negedge clk); #1; endtask

   task automatic set_idle();
      id_valid = 0; id_rs = '0; id_rs_used = '0;
      ex_valid = 0; ex_wreg = 0; ex_is_load = 0; ex_is_mc = 0; ex_rd = '0;
      me_valid = 0; me_wreg = 0; me_rd = '0; redirect = 0; mc_done = 0;
   endtask

   task automatic do_reset();
      tick(); rst = 0; set_idle();
      mid();
      chk("rst pc_en", pc_en, 1);
      chk("rst fwd", fwd_sel, 0);
      chk("rst stall_cnt", stall_cnt, 0);
      tick(); rst = 1;
   endtask

   task automatic enter_mc();
      ex_valid = 1; ex_is_mc = 1;
      mid(); chk("mc entry pc_en", pc_en, 1);
      tick(); set_idle();
   endtask

   initial begin
      rst = 0;
      set_idle();
      do_reset();

      // load-use: lw x5 in EX, add x6,x5,x1 in ID
      id_valid = 1; id_rs = {5'd1, 5'd5}; id_rs_used = 2'b11;
      ex_valid = 1; ex_wreg = 1; ex_is_load = 1; ex_rd = 5'd5;
      mid();
      chk("ld-use pc_en", pc_en, 0);
      chk("ld-use if_id_en", if_id_en, 0);
      chk("ld-use id_ex_flush", id_ex_flush, 1);
      tick(); ex_valid = 0; ex_is_load = 0; me_valid = 1; me_wreg = 1; me_rd = 5'd5;
      mid();
      chk("ld-use release pc_en", pc_en, 1);
      chk("ld-use stall_cnt", stall_cnt, 1);
      tick(); set_idle();
      mid();
      chk("ld-use fwd", fwd_sel, 4'b0010);

      // ALU producer in ME only
      tick(); id_valid = 1; id_rs = {5'd3, 5'd5}; id_rs_used = 2'b11;
      ex_valid = 1; ex_wreg = 1; ex_rd = 5'd7; me_valid = 1; me_wreg = 1; me_rd = 5'd5;
      mid();
      chk("me-fwd pc_en", pc_en, 1);
      tick(); set_idle();
      mid();
      chk("me-fwd fwd", fwd_sel, 4'b0010);

      // x0 never hazards
      tick(); id_valid = 1; id_rs = {5'd4, 5'd0}; id_rs_used = 2'b11;
      ex_valid = 1; ex_wreg = 1; ex_is_load = 1; ex_rd = 5'd0;
      mid();
      chk("x0 pc_en", pc_en, 1);
      tick(); set_idle();
      mid();
      chk("x0 fwd", fwd_sel, 0);

      // multi-cycle op: 5 hold cycles, release on done
      do_reset();
      enter_mc();
      for (int k = 0; k < 5; k++) begin
         mid(); chk("mc hold pc_en", pc_en, 0);
         tick();
      end
      mc_done = 1;
      mid();
      chk("mc done pc_en", pc_en, 1);
      chk("mc done ex_me_flush", ex_me_flush, 0);
      chk("mc stall_cnt", stall_cnt, 5);
      tick(); set_idle();

      // redirect kills a waiting multi-cycle op
      do_reset();
      enter_mc();
      tick(); tick();
      redirect = 1;
      mid();
      chk("redir flushes", {if_id_flush, id_ex_flush, ex_me_flush}, 3'b111);
      tick(); set_idle();
      mid();
      chk("redir abort", mc_abort, 1);
      chk("redir flush_cnt", flush_cnt, 1);
      chk("redir run pc_en", pc_en, 1);
      tick();
      mid();
      chk("redir abort pulse", mc_abort, 0);

      // timeout with no mc_done
      do_reset();
      enter_mc();
      for (int k = 0; k < MCM - 1; k++) tick();
      mid();
      chk("tmo id_ex_flush", id_ex_flush, 1);
      tick();
      mid();
      chk("tmo flag", mc_timeout, 1);
      chk("tmo abort", mc_abort, 1);
      chk("tmo stall_cnt", stall_cnt, MCM);
      tick();
      mid();
      chk("tmo abort pulse", mc_abort, 0);
      chk("tmo sticky", mc_timeout, 1);

      // async reset while waiting: no abort
      do_reset();
      enter_mc();
      mid(); chk("pre-rst hold", pc_en, 0);
      tick(); rst = 0;
      mid();
      chk("rst-wait abort", mc_abort, 0);
      chk("rst-wait pc_en", pc_en, 1);
      tick(); rst = 1;
      mid();
      chk("post-rst abort", mc_abort, 0);
      chk("post-rst pc_en", pc_en, 1);

      for (int k = 0; k < 3000; k++) begin
         tick();
         rst        = ($urandom_range(0, 499) != 0);
         id_valid   = ($urandom_range(0, 3) != 0);
         id_rs      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         id_rs_used = 2'($urandom);
         ex_valid   = ($urandom_range(0, 3) != 0);
         ex_wreg    = ($urandom_range(0, 3) != 0);
         ex_is_load = ($urandom_range(0, 2) == 0);
         ex_is_mc   = ($urandom_range(0, 9) == 0);
         ex_rd      = 5'($urandom_range(0, 3));
         me_valid   = ($urandom_range(0, 3) != 0);
         me_wreg    = ($urandom_range(0, 3) != 0);
         me_rd      = 5'($urandom_range(0, 3));
         redirect   = ($urandom_range(0, 11) == 0);
         mc_done    = ($urandom_range(0, 3) == 0);
      end
      tick(); rst = 1; set_idle();
      mid();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
